// File: rtl/timer_arbiter.sv
// timer_arbiter
// -------------
// Shares one countdown timer (and its tick prescaler) among NREQ requesters,
// e.g. door-open hold, floor-travel delay and display blink. Requesters are
// served round-robin and only one timed interval runs at a time.
//
// Handshake: a requester raises req[i] with dur[i] valid and holds req[i]
// until it sees done[i] for one cycle. dur[i] is sampled only on the grant
// edge. Dropping req[i] while it owns a running interval abandons it: the
// timer returns to IDLE with no done pulse. req of the owner is ignored in
// the DONE cycle.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous, active-high reset
//   req        [NREQ]        level request per requester
//   dur        [NREQ*DUR_W]  duration in ticks, requester i at [i*DUR_W +: DUR_W]
//   gnt        [NREQ]        one-hot current owner, or 0
//   done       [NREQ]        one-cycle pulse on the owner's bit at expiry
//   busy       high whenever the FSM is not IDLE
//   remaining  [DUR_W]       ticks left for the current owner
//   dbg_state  [2]           FSM state (0 IDLE, 1 RUN, 2 DONE)

module timer_arbiter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int NREQ     = 3,
  parameter int DUR_W    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DUR_W-1:0]   dur,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [DUR_W-1:0]        remaining,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   owner_inc;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [DUR_W-1:0]   win_dur;
  logic [DUR_W-1:0]   remaining_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               tick;
  logic [NREQ-1:0]    owner_oh;

  // Round-robin search: first set req bit at or above ptr, wrapping.
  // Iterating from the farthest candidate down lets the nearest one win.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  assign win_dur   = dur[win_idx*DUR_W +: DUR_W];
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;

  // The prescaler only advances in RUN and is zeroed on grant, so the first
  // tick lands exactly TICK_DIV cycles after the grant edge.
  assign tick = (state == RUN) && (cnt == CNT_MAX);

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    ptr_n       = ptr;
    remaining_n = remaining;
    cnt_n       = cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          owner_n     = win_idx;
          remaining_n = win_dur;
          cnt_n       = '0;
          // A zero duration skips RUN and expires immediately.
          state_n     = (win_dur == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          // Abandon wins over a coincident tick: no done pulse.
          state_n     = IDLE;
          remaining_n = '0;
          cnt_n       = '0;
          ptr_n       = owner_inc;
        end else begin
          cnt_n = tick ? '0 : cnt + 1'b1;
          if (tick) begin
            if (remaining <= DUR_W'(1)) begin
              remaining_n = '0;
              state_n     = DONE;
            end else begin
              remaining_n = remaining - 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_n     = IDLE;
        remaining_n = '0;
        cnt_n       = '0;
        ptr_n       = owner_inc;
      end
      default: begin
        state_n     = IDLE;
        remaining_n = '0;
        cnt_n       = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      remaining <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      remaining <= remaining_n;
      cnt       <= cnt_n;
    end
  end

  // Outputs decode straight from registered state so async reset clears
  // them without waiting for a clock edge.
  assign gnt       = (state != IDLE) ? owner_oh : '0;
  assign done      = (state == DONE) ? owner_oh : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  localparam int TICK_DIV = 4;
  localparam int NREQ     = 3;
  localparam int DUR_W    = 8;
  localparam int W        = NREQ;

  logic                  CLK;
  logic                  RST;
  logic [NREQ-1:0]       req;
  logic [NREQ*DUR_W-1:0] dur;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [DUR_W-1:0]      remaining;
  logic [1:0]            dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_gnt;

  timer_arbiter #(
    .TICK_DIV (TICK_DIV),
    .NREQ     (NREQ),
    .DUR_W    (DUR_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .dur       (dur),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle and sample #1 after the edge. A new grant (gnt going
  // from 0 to non-zero) pops the scoreboard.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 32'(gnt), 32'(0));
      else                   chk("grant_order", 32'(gnt), 32'(exp_q.pop_front()));
    end
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    req = '0;
    dur = '0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt",       32'(gnt),       32'(0));
    chk("rst_done",      32'(done),      32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_remaining", 32'(remaining), 32'(0));
    chk("rst_state",     32'(dbg_state), 32'(0));
    RST = 1'b0;
    prev_gnt = '0;
    next_cycle();
  endtask

  // Single requester i with duration d, raised in cycle 0.
  task automatic run_single(input int i, input int d);
    logic [W-1:0] oh;
    int last;
    oh   = W'(1) << i;
    last = d * TICK_DIV + 1;
    req  = oh;
    dur  = '0;
    dur[i*DUR_W +: DUR_W] = DUR_W'(d);
    exp_q.push_back(oh);
    for (int c = 1; c <= last; c++) begin
      next_cycle();
      chk($sformatf("single_gnt_c%0d", c), 32'(gnt), 32'(oh));
      chk($sformatf("single_rem_c%0d", c), 32'(remaining),
          (c == last) ? 32'(0) : 32'(d - (c - 1) / TICK_DIV));
      chk($sformatf("single_done_c%0d", c), 32'(done), (c == last) ? 32'(oh) : 32'(0));
    end
    req = '0;
    next_cycle();
    chk("single_after_gnt",  32'(gnt),  32'(0));
    chk("single_after_busy", 32'(busy), 32'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST      = 1'b1;
    req      = '0;
    dur      = '0;
    prev_gnt = '0;

    // Single request, dur0=3.
    do_reset();
    run_single(0, 3);

    // Zero duration on requester 1.
    do_reset();
    req = 3'b010;
    dur = {8'd0, 8'd0, 8'd0};
    exp_q.push_back(3'b010);
    next_cycle();
    chk("zero_gnt",   32'(gnt),       32'(3'b010));
    chk("zero_done",  32'(done),      32'(3'b010));
    chk("zero_state", 32'(dbg_state), 32'(2));
    chk("zero_rem",   32'(remaining), 32'(0));
    req = '0;
    next_cycle();
    chk("zero_idle_gnt",  32'(gnt),  32'(0));
    chk("zero_idle_busy", 32'(busy), 32'(0));
    chk("zero_idle_done", 32'(done), 32'(0));

    // Simultaneous requests, dur=1 each; each drops req after its done.
    do_reset();
    req = 3'b111;
    dur = {8'd1, 8'd1, 8'd1};
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    for (int c = 1; c <= 18; c++) begin
      int slot;
      int pos;
      next_cycle();
      slot = (c - 1) / 6;
      pos  = (c - 1) % 6;
      chk($sformatf("sim_gnt_c%0d", c), 32'(gnt),
          (pos < 5 && slot < 3) ? (32'(1) << slot) : 32'(0));
      chk($sformatf("sim_done_c%0d", c), 32'(done),
          (pos == 4 && slot < 3) ? (32'(1) << slot) : 32'(0));
      if (done != '0) req = req & ~done;
    end

    // Fairness: req0 and req2 held, dur=2.
    do_reset();
    req = 3'b101;
    dur = {8'd2, 8'd0, 8'd2};
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    for (int c = 1; c <= 40; c++) begin
      int slot;
      int pos;
      logic [31:0] oh;
      next_cycle();
      slot = (c - 1) / 10;
      pos  = (c - 1) % 10;
      oh   = (slot % 2 == 0) ? 32'h1 : 32'h4;
      chk($sformatf("fair_gnt_c%0d", c), 32'(gnt), (pos < 9) ? oh : 32'(0));
      chk($sformatf("fair_done_c%0d", c), 32'(done), (pos == 8) ? oh : 32'(0));
      if (c == 40) req = '0;
    end

    // Abort: req1 dur=5 dropped in cycle 6; req0 (dur=1) pending from cycle 2.
    do_reset();
    req = 3'b010;
    dur = {8'd0, 8'd5, 8'd1};
    exp_q.push_back(3'b010);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if (c <= 6) begin
        chk($sformatf("abort_gnt_c%0d", c), 32'(gnt), 32'(3'b010));
        chk($sformatf("abort_rem_c%0d", c), 32'(remaining), (c <= 4) ? 32'(5) : 32'(4));
      end else begin
        chk("abort_gnt_c7",  32'(gnt),       32'(0));
        chk("abort_rem_c7",  32'(remaining), 32'(0));
        chk("abort_busy_c7", 32'(busy),      32'(0));
      end
      chk($sformatf("abort_done_c%0d", c), 32'(done), 32'(0));
      if (c == 2) begin
        req[0] = 1'b1;
        exp_q.push_back(3'b001);
      end
      if (c == 6) req[1] = 1'b0;
    end
    next_cycle();
    chk("abort_next_gnt_c8", 32'(gnt),       32'(3'b001));
    chk("abort_next_rem_c8", 32'(remaining), 32'(1));
    for (int c = 9; c <= 12; c++) begin
      next_cycle();
      chk($sformatf("abort_next_done_c%0d", c), 32'(done), (c == 12) ? 32'(3'b001) : 32'(0));
    end
    req = '0;
    next_cycle();

    // Reset mid-run, asserted off a clock edge.
    do_reset();
    req = 3'b001;
    dur = {8'd0, 8'd0, 8'd3};
    exp_q.push_back(3'b001);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      chk($sformatf("mid_gnt_c%0d", c), 32'(gnt), 32'(3'b001));
    end
    #3;
    RST = 1'b1;
    #1;
    chk("mid_rst_gnt",  32'(gnt),       32'(0));
    chk("mid_rst_busy", 32'(busy),      32'(0));
    chk("mid_rst_rem",  32'(remaining), 32'(0));
    chk("mid_rst_done", 32'(done),      32'(0));
    req = '0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk($sformatf("mid_hold_done_%0d", c), 32'(done), 32'(0));
      chk($sformatf("mid_hold_gnt_%0d", c),  32'(gnt),  32'(0));
    end
    RST = 1'b0;
    next_cycle();
    run_single(0, 3);

    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one countdown timer and its prescaler among NREQ requesters: door-open hold, floor-travel delay and display blink.
- A requester raises req with a duration in ticks and waits for a one-cycle done pulse.
- Arbitration is round-robin; only one timed interval runs at a time.
- Sits between the elevator control FSM and its timed sub-blocks, clocked from the system CLK.

Parameters:
- TICK_DIV, 50_000_000: CLK cycles per timer tick, ≥2.
- NREQ, 3: number of requesters, ≥2.
- DUR_W, 8: width of each duration field and of the remaining count.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request per requester; held until done or abandoned.
- dur  in  NREQ*DUR_W  duration in ticks; requester i uses bits [i*DUR_W +: DUR_W]; sampled only at grant.
- gnt  out  NREQ  one-hot current owner, or 0.
- done  out  NREQ  one-cycle pulse on the owner's bit at expiry.
- busy  out  1  high whenever state ≠ IDLE.
- remaining  out  DUR_W  ticks left for the current owner.

Behaviour:
- Reset (async, any state) clears everything: state=IDLE, gnt=0, done=0, busy=0, remaining=0, prescaler cnt=0, RR pointer=0.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and is cleared on every grant. tick = (state==RUN && cnt==TICK_DIV-1), combinational and internal.
- State IDLE:
  - If req≠0, the winner is the first set bit at or above the pointer, wrapping around.
  - Next cycle: gnt=onehot(winner), remaining=dur[winner], cnt=0.
  - Go to RUN, or to DONE directly if dur[winner]==0.
  - If req==0, stay in IDLE.
- State RUN:
  - Each tick decrements remaining.
  - A tick with remaining==1 makes remaining 0 and goes to DONE.
  - Abort: req[owner]==0 in any RUN cycle goes to IDLE next cycle, gnt=0, remaining=0, no done, pointer=owner+1 mod NREQ. Abort takes priority over a coincident tick.
- State DONE (one cycle):
  - done[owner]=1 and gnt still asserted.
  - Next cycle: IDLE, gnt=0, pointer=owner+1 mod NREQ.
  - req[owner] is ignored in DONE.
- Timing: req rising in IDLE at cycle 0 gives gnt in cycle 1, RUN in cycles 1..dur*TICK_DIV, and done in cycle dur*TICK_DIV+1. Exact interval, no tick phase jitter.
- Changes to req or dur of non-owners during RUN have no effect. dur of the owner is ignored after grant.
- If the owner still holds req in the IDLE cycle after DONE, it is re-arbitrated from the advanced pointer, so other waiting requesters win first.
- Arbitration always costs one IDLE cycle between grants; back-to-back grants are separated by exactly one cycle with gnt=0.
- remaining is never below 0; a zero duration never reaches RUN.

Test Plan (TICK_DIV=4, NREQ=3, DUR_W=8, cycle 0 = first edge with req set after reset):
- Single request: req=001, dur0=3 → gnt=001 in cycles 1–13; remaining 3→2→1→0 at the ends of cycles 4, 8, 12; done=001 only in cycle 13; gnt=0 and busy=0 from cycle 14.
- Zero duration: req=010, dur1=0 → cycle 1 is DONE with gnt=010 and done=010; IDLE in cycle 2; RUN never entered.
- Simultaneous: req=111, all dur=1, each requester drops req after its done → grants 001, 010, 100 in that order; each grant lasts 5 cycles (4 RUN + 1 DONE) with one idle cycle between grants.
- Fairness: req0 and req2 held high continuously, dur=2 → grant sequence 001, 100, 001, 100; req0 never wins twice in a row.
- Abort: req=010, dur1=5; drop req1 in cycle 6 → gnt=000 and remaining=0 in cycle 7; done never pulses; a pending req0 is granted in cycle 8.
- Reset mid-run: assert RST in cycle 3 of a dur=3 run, asynchronously and off a clock edge → gnt, busy and remaining go to 0 immediately; no done; after release, req=001 restarts a full 12-cycle interval.
